// File: rtl/cache_pkg.sv
// Shared encodings for the cache line refill path: FSM states, AHB constants
// and the layout of a tag-table word {tag[11:0], lru_cnt[1:0], valid}.
package cache_pkg;

    typedef enum logic [1:0] {StIdle, StAddr, StBurst, StWrite} state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;

    localparam int unsigned TagMsb   = 14;
    localparam int unsigned TagLsb   = 3;
    localparam int unsigned LruMsb   = 2;
    localparam int unsigned LruLsb   = 1;
    localparam int unsigned ValidBit = 0;

    function automatic logic [14:0] make_tag_word(input logic [11:0] tag,
                                                  input logic [1:0]  lru,
                                                  input logic        valid);
        return {tag, lru, valid};
    endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// Picks the refill victim of a 4-way set and produces the updated tag words
// (victim gets the new tag, younger ways age by one).
module lru_victim_sel
    import cache_pkg::*;
(
    input  logic [3:0][14:0] ways_i,
    input  logic [11:0]      tag_i,
    output logic [3:0]       victim_oh_o,
    output logic [3:0][14:0] ways_o
);

    logic       any_inv;
    logic [1:0] inv_idx;
    logic [1:0] lru_idx;
    logic [1:0] vidx;
    logic [1:0] old_cnt;
    logic [1:0] cnt;

    always_comb begin
        any_inv = 1'b0;
        inv_idx = 2'd0;
        lru_idx = 2'd0;
        cnt     = 2'd0;
        // Descending scan so the lowest-numbered match wins.
        for (int i = 3; i >= 0; i--) begin
            if (!ways_i[i][ValidBit]) begin
                any_inv = 1'b1;
                inv_idx = i[1:0];
            end
            if (ways_i[i][LruMsb:LruLsb] == 2'd3) begin
                lru_idx = i[1:0];
            end
        end
        vidx        = any_inv ? inv_idx : lru_idx;
        old_cnt     = ways_i[vidx][LruMsb:LruLsb];
        victim_oh_o = 4'b0001 << vidx;

        for (int i = 0; i < 4; i++) begin
            cnt       = ways_i[i][LruMsb:LruLsb];
            ways_o[i] = ways_i[i];
            if (i[1:0] == vidx) begin
                ways_o[i] = make_tag_word(tag_i, 2'b00, 1'b1);
            end else if (cnt < old_cnt && cnt != 2'd3) begin
                ways_o[i][LruMsb:LruLsb] = cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/line_refill_ctrl.sv
// Cache line refill controller: fetches a 16-byte line with one AHB INCR4 read
// and writes it, plus the updated LRU/tag words, into the chosen victim way.
module line_refill_ctrl
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         miss,
    input  logic [17:0]  miss_addr,
    input  logic [14:0]  way0_tag,
    input  logic [14:0]  way1_tag,
    input  logic [14:0]  way2_tag,
    input  logic [14:0]  way3_tag,
    output logic [1:0]   m_htrans,
    output logic [19:0]  m_haddr,
    output logic [2:0]   m_hburst,
    output logic [2:0]   m_hsize,
    output logic         m_hwrite,
    input  logic [31:0]  m_hrdata,
    input  logic         m_hready,
    input  logic [1:0]   m_hresp,
    output logic         tag_wr_en,
    output logic [3:0]   tag_wr_index,
    output logic [14:0]  tag_wr_data0,
    output logic [14:0]  tag_wr_data1,
    output logic [14:0]  tag_wr_data2,
    output logic [14:0]  tag_wr_data3,
    output logic [3:0]   data_wr_en,
    output logic [3:0]   data_wr_index,
    output logic [127:0] data_wr_data,
    output logic [31:0]  refill_rdata,
    output logic         refill_done,
    output logic         refill_err,
    output logic         busy
);

    state_e           state_q;
    logic [17:0]      addr_q;
    logic [3:0][14:0] tags_q;
    logic [127:0]     line_q;
    logic [1:0]       beat_q;
    logic [1:0]       htrans_q;
    logic [19:0]      haddr_q;
    logic             tag_wr_en_q;
    logic [3:0][14:0] tag_wr_data_q;
    logic [3:0]       data_wr_en_q;
    logic [31:0]      rdata_q;
    logic             done_q;
    logic             err_q;

    logic [3:0]       victim_oh;
    logic [3:0][14:0] new_ways;

    lru_victim_sel u_lru_victim_sel (
        .ways_i      (tags_q),
        .tag_i       (addr_q[17:6]),
        .victim_oh_o (victim_oh),
        .ways_o      (new_ways)
    );

    // beat_q is the beat in data phase; the address phase runs one beat ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            tags_q        <= '0;
            line_q        <= '0;
            beat_q        <= '0;
            htrans_q      <= HTRANS_IDLE;
            haddr_q       <= '0;
            tag_wr_en_q   <= 1'b0;
            tag_wr_data_q <= '0;
            data_wr_en_q  <= '0;
            rdata_q       <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            tag_wr_en_q  <= 1'b0;
            data_wr_en_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (miss) begin
                        addr_q   <= miss_addr;
                        tags_q   <= {way3_tag, way2_tag, way1_tag, way0_tag};
                        beat_q   <= 2'd0;
                        htrans_q <= HTRANS_NONSEQ;
                        haddr_q  <= {miss_addr[17:2], 4'h0};
                        state_q  <= StAddr;
                    end
                end
                StAddr: begin
                    if (m_hready) begin
                        htrans_q <= HTRANS_SEQ;
                        haddr_q  <= {addr_q[17:2], 4'h4};
                        state_q  <= StBurst;
                    end
                end
                StBurst: begin
                    if (m_hresp != HRESP_OKAY) begin
                        // First error cycle cancels the pending address; second ends the fill.
                        htrans_q <= HTRANS_IDLE;
                        if (m_hready) begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else if (m_hready) begin
                        for (int k = 0; k < 4; k++) begin
                            if (beat_q == k[1:0]) begin
                                line_q[127-32*k -: 32] <= m_hrdata;
                            end
                        end
                        if (beat_q == addr_q[1:0]) begin
                            rdata_q <= m_hrdata;
                        end
                        if (beat_q == 2'd3) begin
                            tag_wr_en_q   <= 1'b1;
                            tag_wr_data_q <= new_ways;
                            data_wr_en_q  <= victim_oh;
                            done_q        <= 1'b1;
                            state_q       <= StWrite;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                            if (beat_q == 2'd2) begin
                                htrans_q <= HTRANS_IDLE;
                            end else begin
                                htrans_q <= HTRANS_SEQ;
                                haddr_q  <= {addr_q[17:2], beat_q + 2'd2, 2'b00};
                            end
                        end
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_htrans      = htrans_q;
    assign m_haddr       = haddr_q;
    assign m_hburst      = HBURST_INCR4;
    assign m_hsize       = HSIZE_WORD;
    assign m_hwrite      = 1'b0;
    assign tag_wr_en     = tag_wr_en_q;
    assign tag_wr_index  = addr_q[5:2];
    assign tag_wr_data0  = tag_wr_data_q[0];
    assign tag_wr_data1  = tag_wr_data_q[1];
    assign tag_wr_data2  = tag_wr_data_q[2];
    assign tag_wr_data3  = tag_wr_data_q[3];
    assign data_wr_en    = data_wr_en_q;
    assign data_wr_index = addr_q[5:2];
    assign data_wr_data  = line_q;
    assign refill_rdata  = rdata_q;
    assign refill_done   = done_q;
    assign refill_err    = err_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Directed bench for line_refill_ctrl: a vector table of zero-wait refills plus
// hand-built wait-state, bus-error, mid-burst reset and repeated-miss sequences.
module tb_line_refill_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss;
    logic [17:0]  miss_addr;
    logic [3:0][14:0] cur_tags;
    logic [1:0]   m_htrans;
    logic [19:0]  m_haddr;
    logic [2:0]   m_hburst;
    logic [2:0]   m_hsize;
    logic         m_hwrite;
    logic [31:0]  m_hrdata;
    logic         m_hready;
    logic [1:0]   m_hresp;
    logic         tag_wr_en;
    logic [3:0]   tag_wr_index;
    logic [14:0]  tag_wr_data0, tag_wr_data1, tag_wr_data2, tag_wr_data3;
    logic [3:0]   data_wr_en;
    logic [3:0]   data_wr_index;
    logic [127:0] data_wr_data;
    logic [31:0]  refill_rdata;
    logic         refill_done;
    logic         refill_err;
    logic         busy;

    always #5 clk = ~clk;

    line_refill_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .miss          (miss),
        .miss_addr     (miss_addr),
        .way0_tag      (cur_tags[0]),
        .way1_tag      (cur_tags[1]),
        .way2_tag      (cur_tags[2]),
        .way3_tag      (cur_tags[3]),
        .m_htrans      (m_htrans),
        .m_haddr       (m_haddr),
        .m_hburst      (m_hburst),
        .m_hsize       (m_hsize),
        .m_hwrite      (m_hwrite),
        .m_hrdata      (m_hrdata),
        .m_hready      (m_hready),
        .m_hresp       (m_hresp),
        .tag_wr_en     (tag_wr_en),
        .tag_wr_index  (tag_wr_index),
        .tag_wr_data0  (tag_wr_data0),
        .tag_wr_data1  (tag_wr_data1),
        .tag_wr_data2  (tag_wr_data2),
        .tag_wr_data3  (tag_wr_data3),
        .data_wr_en    (data_wr_en),
        .data_wr_index (data_wr_index),
        .data_wr_data  (data_wr_data),
        .refill_rdata  (refill_rdata),
        .refill_done   (refill_done),
        .refill_err    (refill_err),
        .busy          (busy)
    );

    // Slave memory: each word reads back as a tag of its own byte address.
    function automatic logic [31:0] beat_word(input logic [19:0] a);
        return 32'hDA00_0000 | {12'h0, a};
    endfunction

    logic        dp_valid = 1'b0;
    logic [19:0] dp_addr  = '0;
    always @(posedge clk) begin
        if (m_hready) begin
            dp_valid <= m_htrans[1];
            dp_addr  <= m_haddr;
        end
    end
    assign m_hrdata = dp_valid ? beat_word(dp_addr) : 32'h0;

    typedef struct {
        logic [17:0]      addr;
        logic [3:0][14:0] tags;
        logic [19:0]      base;
        logic [3:0]       idx;
        logic [3:0]       we;
        logic [3:0][14:0] exp_tags;
    } vec_t;

    vec_t vecs[5];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-run observations, indexed by cycle offset from the miss cycle.
    logic [1:0]   snap_htrans[16];
    logic [19:0]  snap_haddr[16];
    logic         snap_busy[16];
    logic         snap_strobe[16];
    logic [19:0]  r_addr[8];
    int           r_naddr, r_nonseq, r_done_cnt, r_done_cyc, r_err_cnt, r_err_cyc;
    int           r_twe_cnt, r_dwe_cnt;
    logic [3:0]   r_we, r_idx, r_tidx;
    logic [3:0][14:0] r_tdata;
    logic [127:0] r_line;
    logic [31:0]  r_rdata;

    task automatic run(input int vi, input int wait_cyc, input int wait_len,
                       input int err_cyc, input int reset_cyc, input bit remiss);
        r_naddr = 0; r_nonseq = 0; r_done_cnt = 0; r_done_cyc = -1;
        r_err_cnt = 0; r_err_cyc = -1; r_twe_cnt = 0; r_dwe_cnt = 0;
        @(negedge clk);
        miss      = 1'b1;
        miss_addr = vecs[vi].addr;
        cur_tags  = vecs[vi].tags;
        m_hready  = 1'b1;
        m_hresp   = 2'b00;
        reset     = 1'b0;
        for (int c = 1; c < 15; c++) begin
            @(negedge clk);
            miss     = remiss && c >= 2 && c <= 5;
            reset    = (c == reset_cyc);
            m_hready = !((c >= wait_cyc && c < wait_cyc + wait_len) || c == err_cyc);
            m_hresp  = (c == err_cyc || c == err_cyc + 1) ? 2'b01 : 2'b00;
            snap_htrans[c] = m_htrans;
            snap_haddr[c]  = m_haddr;
            snap_busy[c]   = busy;
            snap_strobe[c] = tag_wr_en | refill_done | refill_err | (|data_wr_en);
            if (m_htrans[1] && m_hready) begin
                if (m_htrans == 2'b10) r_nonseq++;
                if (r_naddr < 8) r_addr[r_naddr] = m_haddr;
                r_naddr++;
            end
            if (tag_wr_en) r_twe_cnt++;
            if (data_wr_en != 4'b0) r_dwe_cnt++;
            if (refill_err) begin
                r_err_cnt++;
                r_err_cyc = c;
            end
            if (refill_done) begin
                if (r_done_cnt == 0) begin
                    r_done_cyc = c;
                    r_we    = data_wr_en;
                    r_idx   = data_wr_index;
                    r_tidx  = tag_wr_index;
                    r_tdata = {tag_wr_data3, tag_wr_data2, tag_wr_data1, tag_wr_data0};
                    r_line  = data_wr_data;
                    r_rdata = refill_rdata;
                end
                r_done_cnt++;
            end
        end
        miss     = 1'b0;
        reset    = 1'b0;
        m_hready = 1'b1;
        m_hresp  = 2'b00;
    endtask

    task automatic check_fill(input int vi, input int exp_done, input string tag);
        logic [19:0]  b;
        logic [127:0] line;
        b    = vecs[vi].base;
        line = {beat_word(b), beat_word(b + 20'd4), beat_word(b + 20'd8), beat_word(b + 20'd12)};
        chk({tag, " nonseq_c1"}, {110'h0, snap_htrans[1]}, 128'h2);
        chk({tag, " haddr_c1"}, {108'h0, snap_haddr[1]}, {108'h0, b});
        chk({tag, " naddr"}, r_naddr, 4);
        for (int k = 0; k < 4; k++) begin
            chk({tag, " beat_addr"}, {108'h0, r_addr[k]}, {108'h0, b + 20'(4 * k)});
        end
        chk({tag, " nonseq_cnt"}, r_nonseq, 1);
        chk({tag, " done_cyc"}, r_done_cyc, exp_done);
        chk({tag, " done_cnt"}, r_done_cnt, 1);
        chk({tag, " tag_we_cnt"}, r_twe_cnt, 1);
        chk({tag, " data_we_cnt"}, r_dwe_cnt, 1);
        chk({tag, " err_cnt"}, r_err_cnt, 0);
        chk({tag, " data_wr_en"}, {124'h0, r_we}, {124'h0, vecs[vi].we});
        chk({tag, " index"}, {124'h0, r_idx}, {124'h0, vecs[vi].idx});
        chk({tag, " tag_index"}, {124'h0, r_tidx}, {124'h0, vecs[vi].idx});
        chk({tag, " tag_words"}, {68'h0, r_tdata}, {68'h0, vecs[vi].exp_tags});
        chk({tag, " line"}, r_line, line);
        chk({tag, " rdata"}, {96'h0, r_rdata},
            {96'h0, beat_word(b + {16'h0, vecs[vi].addr[1:0], 2'b00})});
    endtask

    initial begin
        vecs[0] = '{18'h01234, {4{15'h0}}, 20'h048D0, 4'hD, 4'b0001,
                    {15'h0, 15'h0, 15'h0, 15'h241}};
        vecs[1] = '{18'h3FFFF, {15'h2225, 15'h199F, 15'h1113, 15'h0889},
                    20'hFFFF0, 4'hF, 4'b0100,
                    {15'h2227, 15'h7FF9, 15'h1115, 15'h088B}};
        vecs[2] = '{18'h0A5A6, {15'h06EF, 15'h0663, 15'h05DC, 15'h0557},
                    20'h29690, 4'h9, 4'b0010,
                    {15'h06EF, 15'h0665, 15'h14B1, 15'h0557}};
        vecs[3] = '{18'h00001, {15'h0025, 15'h001B, 15'h0011, 15'h000D},
                    20'h00000, 4'h0, 4'b0001,
                    {15'h0025, 15'h001D, 15'h0013, 15'h0001}};
        vecs[4] = '{18'h20000, {15'h0200, 15'h0182, 15'h0107, 15'h0087},
                    20'h80000, 4'h0, 4'b0100,
                    {15'h0202, 15'h4001, 15'h0107, 15'h0087}};

        reset = 1'b1; miss = 1'b0; miss_addr = '0; cur_tags = '0;
        m_hready = 1'b1; m_hresp = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst htrans", {126'h0, m_htrans}, 128'h0);
        chk("rst haddr", {108'h0, m_haddr}, 128'h0);
        chk("rst hburst", {125'h0, m_hburst}, 128'h3);
        chk("rst hsize", {125'h0, m_hsize}, 128'h2);
        chk("rst hwrite", {127'h0, m_hwrite}, 128'h0);
        chk("rst strobes", {124'h0, tag_wr_en, refill_done, refill_err, busy}, 128'h0);
        chk("rst data_wr_en", {124'h0, data_wr_en}, 128'h0);
        chk("rst tag_data", {68'h0, tag_wr_data3, tag_wr_data2, tag_wr_data1, tag_wr_data0},
            128'h0);
        chk("rst line", data_wr_data, 128'h0);
        chk("rst rdata", {96'h0, refill_rdata}, 128'h0);
        reset = 1'b0;

        // Zero-wait refills across victim-selection cases.
        for (int v = 0; v < 5; v++) begin
            run(v, 0, 0, -10, -1, 1'b0);
            check_fill(v, 6, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d idle_c7", v), {127'h0, snap_busy[7]}, 128'h0);
        end

        // Two wait states on the beat-2 data phase.
        run(0, 4, 2, -10, -1, 1'b0);
        check_fill(0, 8, "wait");
        chk("wait htrans_c4", {126'h0, snap_htrans[4]}, 128'h3);
        chk("wait htrans_c5", {126'h0, snap_htrans[5]}, 128'h3);
        chk("wait haddr_c4", {108'h0, snap_haddr[4]}, 128'h048DC);
        chk("wait haddr_c5", {108'h0, snap_haddr[5]}, 128'h048DC);

        // ERROR response on beat 1.
        run(1, 0, 0, 3, -1, 1'b0);
        chk("err htrans_c4", {126'h0, snap_htrans[4]}, 128'h0);
        chk("err err_cyc", r_err_cyc, 5);
        chk("err err_cnt", r_err_cnt, 1);
        chk("err done_cnt", r_done_cnt, 0);
        chk("err tag_we_cnt", r_twe_cnt, 0);
        chk("err data_we_cnt", r_dwe_cnt, 0);
        chk("err busy_c5", {127'h0, snap_busy[5]}, 128'h0);

        // Reset in the middle of the burst, then a clean refill.
        run(2, 0, 0, -10, 3, 1'b0);
        chk("rstb busy_c4", {127'h0, snap_busy[4]}, 128'h0);
        chk("rstb htrans_c4", {126'h0, snap_htrans[4]}, 128'h0);
        chk("rstb strobe_c4", {127'h0, snap_strobe[4]}, 128'h0);
        chk("rstb done_cnt", r_done_cnt, 0);
        chk("rstb tag_we_cnt", r_twe_cnt, 0);
        run(2, 0, 0, -10, -1, 1'b0);
        check_fill(2, 6, "after_rst");

        // Miss held high while busy must not start a second burst.
        run(3, 0, 0, -10, -1, 1'b1);
        check_fill(3, 6, "remiss");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
